// File: rtl/pipelined_mux_n_if.sv
// Port bundle for pipelined_mux_n: sample inputs, the registered selected word and the error flag.
interface pipelined_mux_n_if #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 8,
    parameter int SEL_WIDTH  = 3
);
    logic                        enable;
    logic                        in_valid;
    logic [SEL_WIDTH-1:0]        selector;
    logic [WIDTH*NUM_INPUTS-1:0] data_in;
    logic                        err_clear;
    logic [WIDTH-1:0]            data_output;
    logic                        out_valid;
    logic [SEL_WIDTH-1:0]        sel_out;
    logic                        sel_error;

    modport slave (
        input  enable, in_valid, selector, data_in, err_clear,
        output data_output, out_valid, sel_out, sel_error
    );

    modport master (
        output enable, in_valid, selector, data_in, err_clear,
        input  data_output, out_valid, sel_out, sel_error
    );
endinterface

// File: rtl/pipelined_mux_n.sv
// Registered N-to-1 word mux with 1- or 2-stage pipeline, stall and a sticky out-of-range selector flag.
module pipelined_mux_n #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 8,
    parameter int SEL_WIDTH  = 3,
    parameter int LATENCY    = 1
) (
    input logic              clk,
    input logic              reset,
    pipelined_mux_n_if.slave mux_if
);
    if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
        $error("pipelined_mux_n: LATENCY must be 1 or 2");
    end
    if (NUM_INPUTS < 2 || NUM_INPUTS > (1 << SEL_WIDTH)) begin : g_bad_inputs
        $error("pipelined_mux_n: NUM_INPUTS must be in 2..2**SEL_WIDTH");
    end

    logic                 sel_legal;
    logic                 take;
    logic                 take_bad;
    logic [WIDTH-1:0]     sel_word;
    logic                 src_valid;
    logic [WIDTH-1:0]     src_word;
    logic [SEL_WIDTH-1:0] src_sel;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic                 err_q, err_d;

    assign sel_legal = int'(mux_if.selector) < NUM_INPUTS;
    assign take      = mux_if.enable & mux_if.in_valid & sel_legal;
    assign take_bad  = mux_if.enable & mux_if.in_valid & ~sel_legal;

    // Only legal codes are decoded, so unused codes never index past data_in.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (int'(mux_if.selector) == k) sel_word = mux_if.data_in[k*WIDTH +: WIDTH];
        end
    end

    if (LATENCY == 2) begin : g_stage_a
        logic                 a_valid_q, a_valid_d;
        logic [WIDTH-1:0]     a_word_q, a_word_d;
        logic [SEL_WIDTH-1:0] a_sel_q, a_sel_d;

        always_comb begin
            a_valid_d = a_valid_q;
            a_word_d  = a_word_q;
            a_sel_d   = a_sel_q;
            if (mux_if.enable) begin
                a_valid_d = take;
                if (take) begin
                    a_word_d = sel_word;
                    a_sel_d  = mux_if.selector;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                a_valid_q <= 1'b0;
                a_word_q  <= '0;
                a_sel_q   <= '0;
            end else begin
                a_valid_q <= a_valid_d;
                a_word_q  <= a_word_d;
                a_sel_q   <= a_sel_d;
            end
        end

        assign src_valid = a_valid_q;
        assign src_word  = a_word_q;
        assign src_sel   = a_sel_q;
    end else begin : g_direct
        assign src_valid = take;
        assign src_word  = sel_word;
        assign src_sel   = mux_if.selector;
    end

    // Word and selector only move on a delivered sample; the valid pulse is cleared by any enabled edge.
    always_comb begin
        out_valid_d = out_valid_q;
        data_d      = data_q;
        sel_d       = sel_q;
        if (mux_if.enable) begin
            out_valid_d = src_valid;
            if (src_valid) begin
                data_d = src_word;
                sel_d  = src_sel;
            end
        end
    end

    // Set beats clear; clear is honoured even while the pipeline is stalled.
    assign err_d = take_bad | (err_q & ~mux_if.err_clear);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            sel_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            err_q       <= err_d;
        end
    end

    assign mux_if.data_output = data_q;
    assign mux_if.out_valid   = out_valid_q;
    assign mux_if.sel_out     = sel_q;
    assign mux_if.sel_error   = err_q;
endmodule

// File: tb/tb_pipelined_mux_n.sv
// Bench for pipelined_mux_n: three configurations driven in parallel against a history-based reference model.
module tb_pipelined_mux_n;
    localparam int HN = 4096;
    localparam int LAT [3] = '{1, 2, 1};
    localparam int NN  [3] = '{8, 8, 6};

    logic         clk;
    logic         rst;
    logic         en, iv, clr;
    logic [2:0]   sel;
    logic [255:0] d8;

    int checks = 0;
    int errors = 0;

    pipelined_mux_n_if #(.WIDTH(32), .NUM_INPUTS(8), .SEL_WIDTH(3)) if0 ();
    pipelined_mux_n_if #(.WIDTH(32), .NUM_INPUTS(8), .SEL_WIDTH(3)) if1 ();
    pipelined_mux_n_if #(.WIDTH(32), .NUM_INPUTS(6), .SEL_WIDTH(3)) if2 ();

    assign if0.enable = en;  assign if0.in_valid = iv;  assign if0.selector = sel;
    assign if0.err_clear = clr;  assign if0.data_in = d8;
    assign if1.enable = en;  assign if1.in_valid = iv;  assign if1.selector = sel;
    assign if1.err_clear = clr;  assign if1.data_in = d8;
    assign if2.enable = en;  assign if2.in_valid = iv;  assign if2.selector = sel;
    assign if2.err_clear = clr;  assign if2.data_in = d8[191:0];

    pipelined_mux_n #(.WIDTH(32), .NUM_INPUTS(8), .SEL_WIDTH(3), .LATENCY(1))
        u0 (.clk(clk), .reset(rst), .mux_if(if0));
    pipelined_mux_n #(.WIDTH(32), .NUM_INPUTS(8), .SEL_WIDTH(3), .LATENCY(2))
        u1 (.clk(clk), .reset(rst), .mux_if(if1));
    pipelined_mux_n #(.WIDTH(32), .NUM_INPUTS(6), .SEL_WIDTH(3), .LATENCY(1))
        u2 (.clk(clk), .reset(rst), .mux_if(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Reference model: every enabled edge records what was offered; the output of a
    // LATENCY-L instance is whatever was offered L-1 enabled edges earlier, if legal.
    typedef struct {
        logic        v;
        logic [2:0]  s;
        logic [31:0] w;
    } hrec_t;

    hrec_t       hist [HN];
    int          ecnt;
    logic [31:0] m_data [3];
    logic [2:0]  m_sel  [3];
    logic        m_ov   [3];
    logic        m_err  [3];

    task automatic model_reset();
        ecnt = 0;
        for (int i = 0; i < 3; i++) begin
            m_data[i] = '0; m_sel[i] = '0; m_ov[i] = 1'b0; m_err[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int src;
        for (int i = 0; i < 3; i++)
            m_err[i] = (en && iv && int'(sel) >= NN[i]) || (m_err[i] && !clr);
        if (en) begin
            hist[ecnt % HN].v = iv;
            hist[ecnt % HN].s = sel;
            hist[ecnt % HN].w = d8[int'(sel)*32 +: 32];
            for (int i = 0; i < 3; i++) begin
                src = ecnt - (LAT[i] - 1);
                if (src >= 0 && hist[src % HN].v && int'(hist[src % HN].s) < NN[i]) begin
                    m_ov[i]   = 1'b1;
                    m_data[i] = hist[src % HN].w;
                    m_sel[i]  = hist[src % HN].s;
                end else begin
                    m_ov[i] = 1'b0;
                end
            end
            ecnt++;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic check_all();
        chk("u0 data", if0.data_output, m_data[0]);
        chk("u0 sel", 32'(if0.sel_out), 32'(m_sel[0]));
        chk("u0 ov", 32'(if0.out_valid), 32'(m_ov[0]));
        chk("u0 err", 32'(if0.sel_error), 32'(m_err[0]));
        chk("u1 data", if1.data_output, m_data[1]);
        chk("u1 sel", 32'(if1.sel_out), 32'(m_sel[1]));
        chk("u1 ov", 32'(if1.out_valid), 32'(m_ov[1]));
        chk("u1 err", 32'(if1.sel_error), 32'(m_err[1]));
        chk("u2 data", if2.data_output, m_data[2]);
        chk("u2 sel", 32'(if2.sel_out), 32'(m_sel[2]));
        chk("u2 ov", 32'(if2.out_valid), 32'(m_ov[2]));
        chk("u2 err", 32'(if2.sel_error), 32'(m_err[2]));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " u0 data"}, if0.data_output, 32'h0);
        chk({tag, " u0 ov"}, 32'(if0.out_valid), 32'h0);
        chk({tag, " u0 sel"}, 32'(if0.sel_out), 32'h0);
        chk({tag, " u0 err"}, 32'(if0.sel_error), 32'h0);
        chk({tag, " u1 data"}, if1.data_output, 32'h0);
        chk({tag, " u1 ov"}, 32'(if1.out_valid), 32'h0);
        chk({tag, " u1 sel"}, 32'(if1.sel_out), 32'h0);
        chk({tag, " u2 data"}, if2.data_output, 32'h0);
        chk({tag, " u2 ov"}, 32'(if2.out_valid), 32'h0);
        chk({tag, " u2 err"}, 32'(if2.sel_error), 32'h0);
    endtask

    // Inputs are set by the caller away from the edge; outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    typedef struct {
        logic        en, iv;
        logic [2:0]  sel;
        logic        clr;
        logic        ov0;
        logic [31:0] d0;
        logic [2:0]  s0;
        logic        ov2;
        logic [31:0] d2;
        logic        err2;
    } vec_t;

    vec_t tbl [$];

    initial begin
        vec_t r;
        en = 1'b0; iv = 1'b0; sel = '0; clr = 1'b0; d8 = '0; rst = 1'b0;
        model_reset();

        for (int k = 0; k < 8; k++) begin
            r.en = 1'b1; r.iv = 1'b1; r.sel = 3'(k); r.clr = 1'b0;
            r.ov0 = 1'b1; r.d0 = 32'hA0 + 32'(k); r.s0 = 3'(k);
            r.ov2 = (k < 6); r.d2 = (k < 6) ? 32'hA0 + 32'(k) : 32'hA5; r.err2 = (k >= 6);
            tbl.push_back(r);
        end
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 32'hA7, 3'd7, 1'b0, 32'hA5, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 32'hA2, 3'd2, 1'b1, 32'hA2, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 32'hA7, 3'd7, 1'b0, 32'hA2, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 3'd7, 1'b1, 1'b0, 32'hA7, 3'd7, 1'b0, 32'hA2, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 32'hA7, 3'd7, 1'b0, 32'hA2, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 3'd6, 1'b1, 1'b1, 32'hA6, 3'd6, 1'b0, 32'hA2, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 32'hA6, 3'd6, 1'b0, 32'hA2, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 32'hA7, 3'd7, 1'b0, 32'hA2, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 32'hA7, 3'd7, 1'b0, 32'hA2, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'hA7, 3'd7, 1'b0, 32'hA2, 1'b0});

        // Reset state, asserted without a clock edge.
        #2 rst = 1'b1;
        #2 chk_zero("por");
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) d8[k*32 +: 32] = 32'hA0 + 32'(k);
        foreach (tbl[i]) begin
            en = tbl[i].en; iv = tbl[i].iv; sel = tbl[i].sel; clr = tbl[i].clr;
            step();
            chk($sformatf("tbl%0d u0 ov", i), 32'(if0.out_valid), 32'(tbl[i].ov0));
            chk($sformatf("tbl%0d u0 data", i), if0.data_output, tbl[i].d0);
            chk($sformatf("tbl%0d u0 sel", i), 32'(if0.sel_out), 32'(tbl[i].s0));
            chk($sformatf("tbl%0d u2 ov", i), 32'(if2.out_valid), 32'(tbl[i].ov2));
            chk($sformatf("tbl%0d u2 data", i), if2.data_output, tbl[i].d2);
            chk($sformatf("tbl%0d u2 err", i), 32'(if2.sel_error), 32'(tbl[i].err2));
        end
        clr = 1'b0;

        // Two-stage latency: single pulse with selector 5.
        d8[5*32 +: 32] = 32'h5555_0005;
        en = 1'b1; iv = 1'b1; sel = 3'd5;
        step();
        chk("lat2 t ov", 32'(if1.out_valid), 32'h0);
        iv = 1'b0; sel = 3'd0;
        step();
        chk("lat2 t+1 ov", 32'(if1.out_valid), 32'h1);
        chk("lat2 t+1 data", if1.data_output, 32'h5555_0005);
        chk("lat2 t+1 sel", 32'(if1.sel_out), 32'h5);
        step();
        chk("lat2 t+2 ov", 32'(if1.out_valid), 32'h0);
        chk("lat2 t+2 data", if1.data_output, 32'h5555_0005);

        // Stall with a sample in flight.
        iv = 1'b1; sel = 3'd3;
        step();
        chk("stall pre u0 ov", 32'(if0.out_valid), 32'h1);
        chk("stall pre u0 data", if0.data_output, 32'hA3);
        en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            iv = 1'($urandom_range(0, 1)); sel = 3'($urandom_range(0, 7));
            step();
            chk("stall u0 ov", 32'(if0.out_valid), 32'h1);
            chk("stall u0 data", if0.data_output, 32'hA3);
            chk("stall u1 ov", 32'(if1.out_valid), 32'h0);
            chk("stall u1 data", if1.data_output, 32'h5555_0005);
        end
        en = 1'b1; iv = 1'b0;
        step();
        chk("resume u0 ov", 32'(if0.out_valid), 32'h0);
        chk("resume u1 ov", 32'(if1.out_valid), 32'h1);
        chk("resume u1 data", if1.data_output, 32'hA3);
        chk("resume u1 sel", 32'(if1.sel_out), 32'h3);
        step();
        chk("resume+1 u1 ov", 32'(if1.out_valid), 32'h0);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 8; k++) d8[k*32 +: 32] = $urandom;
            en  = ($urandom_range(0, 3) != 0);
            iv  = 1'($urandom_range(0, 1));
            sel = 3'($urandom_range(0, 7));
            clr = ($urandom_range(0, 9) == 0);
            step();
        end

        // Asynchronous reset mid-cycle with a sample held in stage A.
        en = 1'b1; iv = 1'b1; sel = 3'd4; clr = 1'b0;
        step();
        #2 rst = 1'b1;
        #1 chk_zero("async");
        model_reset();
        @(negedge clk);
        rst = 1'b0; iv = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("post-rst u1 ov", 32'(if1.out_valid), 32'h0);
            chk("post-rst u1 data", if1.data_output, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_mux_n.md
Name: pipelined_mux_n

Overview:
- Parametrised, registered N-to-1 word multiplexer that succeeds the fixed 8-input combinational datapath mux in the MIPS datapath.
- Selects one of NUM_INPUTS words, qualifies it with a valid strobe and passes it through a 1- or 2-stage register pipeline with stall support.
- Detects out-of-range selector codes and reports them through a sticky error flag.
- Used where a mux output feeds a timing-critical path, for example ALU source or PC source selection in a pipelined core.

Parameters:
- WIDTH, 32, bits per data word.
- NUM_INPUTS, 8, number of selectable words; legal range 2..2**SEL_WIDTH.
- SEL_WIDTH, 3, selector width in bits.
- LATENCY, 1, number of register stages from input to output; legal values 1 or 2.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  pipeline advance; 0 freezes every register.
- in_valid  input  1  the current selector/data sample is meaningful.
- selector  input  SEL_WIDTH  index of the word to forward.
- data_in  input  WIDTH*NUM_INPUTS  packed input words; word k occupies bits [k*WIDTH +: WIDTH].
- err_clear  input  1  clears sel_error.
- data_output  output  WIDTH  selected word, registered.
- out_valid  output  1  data_output was updated by a valid sample this cycle.
- sel_out  output  SEL_WIDTH  selector value that produced the current data_output.
- sel_error  output  1  sticky flag: a valid sample carried selector >= NUM_INPUTS.

Behaviour:
- Reset:
  - Clock is clk; reset is asynchronous and active-high.
  - On reset assertion, data_output=0, out_valid=0, sel_out=0 and sel_error=0 immediately, without waiting for a clock edge.
  - All internal stage registers and valid bits clear.
  - Reset mid-pipeline discards in-flight samples; none emerge after release.
- Sample acceptance:
  - A sample is accepted on a rising clk edge when enable=1 and in_valid=1.
  - A sample is legal if selector < NUM_INPUTS; the word is data_in[selector*WIDTH +: WIDTH].
- LATENCY=1:
  - A legal sample accepted at edge t appears on data_output, with sel_out and out_valid=1, after edge t.
- LATENCY=2:
  - At edge t, stage A captures the selected word, the selector and a valid bit.
  - Stage A moves to the output at edge t+1, so the result appears after edge t+1.
  - Selection is done before stage A; the unselected inputs are not registered.
- Output hold:
  - data_output and sel_out change only when a legal valid sample reaches the output stage; otherwise they hold their last value.
  - out_valid is a one-cycle pulse per legal sample delivered.
  - out_valid=0 on any edge with enable=1 and no legal sample arriving.
- Stall (enable=0):
  - Every register holds, including out_valid. A pending pulse stays asserted until the next enabled edge.
  - The in_valid and selector inputs are ignored.
  - err_clear is still honoured during stall.
- Illegal selector:
  - A valid sample with selector >= NUM_INPUTS is dropped at acceptance, so no output update and no out_valid pulse ever result from it.
  - sel_error is set on that edge, at acceptance and not at output time.
  - Samples with in_valid=0 never set sel_error, whatever the selector value.
- sel_error clear:
  - sel_error stays 1 until an edge with err_clear=1.
  - If a new illegal sample and err_clear=1 occur on the same edge, set wins and sel_error stays 1.
- Back-to-back:
  - A new sample may be accepted every enabled cycle; throughput is 1 per cycle.
  - Order is preserved; no bubbles are inserted.
- Parameters:
  - NUM_INPUTS below 2**SEL_WIDTH leaves unused codes; these are illegal by the rule above.
  - LATENCY values outside {1,2} are a configuration error, flagged at elaboration.

Test Plan:
1. Reset, then defaults (WIDTH=32, N=8, LATENCY=1), data_in word k = 32'hA0+k, enable=1, in_valid=1, sweep selector 0..7 on consecutive cycles -> data_output = 32'hA0..32'hA7 one cycle after each, out_valid high for 8 cycles, sel_out tracks 0..7.
2. LATENCY=2, selector=5, single in_valid pulse at edge t -> data_output = word 5 and out_valid=1 only after edge t+1; out_valid low after t+2.
3. N=6, SEL_WIDTH=3, legal sample sel=2, then in_valid=1 with sel=7 -> sel_error=1 at that edge, no out_valid pulse, data_output holds word 2; err_clear pulse -> sel_error=0; sel=7 with in_valid=0 -> sel_error stays 0.
4. Stall: accept sel=3, drop enable for 4 cycles while toggling selector/in_valid -> outputs and out_valid frozen; on re-enable the pipeline resumes with no lost or duplicated samples.
5. Same-edge err_clear=1 and illegal valid sample -> sel_error remains 1.
6. Assert reset asynchronously mid-cycle with LATENCY=2 and a sample in stage A -> outputs zero immediately; after release no out_valid appears without new input.
